rot_dma_seq: RTL and testbench
==============================

ROT_DMA_SEQ -- requirements
Module: rot_dma_seq

Interface
REQ-001 Parameter BURST_WORDS, default 16, meaning 32-bit words per block transfer, legal range 1..16.
REQ-002 Parameter HSIZE_WORD, default 3'b010, meaning AHB transfer size driven on O_SIZE.
REQ-003 I_HCLK  in  1  the single clock; all logic on its rising edge.
REQ-004 I_HRESET_N  in  1  synchronous active-low reset.
REQ-005 I_GO  in  1  one-cycle frame start request.
REQ-006 I_ABORT  in  1  level; requests early termination of the frame.
REQ-007 I_SRC_ADDR  in  32  source frame base byte address, sampled on accepted I_GO.
REQ-008 I_DST_ADDR  in  32  destination frame base byte address, sampled on accepted I_GO.
REQ-009 I_NUM_BLOCKS  in  16  blocks per frame, sampled on accepted I_GO.
REQ-010 I_PAUSE  in  1  level; forwarded to O_BUSY to insert AHB BUSY cycles.
REQ-011 I_DMA_READY  in  1  DMA engine idle/complete indication.
REQ-012 I_CORE_DONE  in  1  one-cycle pulse; rotation core finished the current block.
REQ-013 O_START  out  1  one-cycle DMA burst start pulse.
REQ-014 O_ADDR  out  32  burst start byte address.
REQ-015 O_SIZE  out  3  transfer size; constant HSIZE_WORD.
REQ-016 O_COUNT  out  5  beats per burst; constant BURST_WORDS.
REQ-017 O_WRITE  out  1  0 = read burst, 1 = write burst.
REQ-018 O_BUSY  out  1  equals I_PAUSE while in RD_WAIT or WR_WAIT, else 0.
REQ-019 O_CORE_START  out  1  one-cycle pulse starting the rotation core on a loaded block.
REQ-020 O_FRAME_BUSY  out  1  high in every state except IDLE.
REQ-021 O_DONE  out  1  one-cycle pulse at frame end (normal or aborted).
REQ-022 O_ABORTED  out  1  registered; set with O_DONE when the frame was aborted, cleared on next accepted I_GO.
REQ-023 O_BLOCK_IDX  out  16  index of the block currently in progress.

Function
REQ-024 States SHALL be IDLE, RD_REQ, RD_WAIT, PROC, WR_REQ, WR_WAIT, FIN.
REQ-025 IDLE: I_GO accepted only in IDLE; I_GO in any other state SHALL be ignored.
REQ-026 Accepted I_GO with I_NUM_BLOCKS=0 -> FIN directly, no O_START issued.
REQ-027 Accepted I_GO with I_NUM_BLOCKS>0 -> RD_REQ, block index cleared to 0.
REQ-028 RD_REQ: O_START=1, O_WRITE=0, O_ADDR=src+idx*BURST_WORDS*4 (modulo 2^32) for exactly one cycle, then RD_WAIT.
REQ-029 WAIT states: completion SHALL be detected as I_DMA_READY sampled 0 then later sampled 1; a ready level present before the drop SHALL NOT count.
REQ-030 RD_WAIT completion -> PROC, O_CORE_START pulsed on the transition cycle.
REQ-031 PROC: wait for I_CORE_DONE, then WR_REQ; I_CORE_DONE outside PROC SHALL be ignored.
REQ-032 WR_REQ: O_START=1, O_WRITE=1, O_ADDR=dst+idx*BURST_WORDS*4, one cycle, then WR_WAIT.
REQ-033 WR_WAIT completion: if idx=I_NUM_BLOCKS-1 -> FIN, else idx+1 and -> RD_REQ.
REQ-034 FIN: O_DONE=1 for one cycle, then IDLE.
REQ-035 O_WRITE and O_ADDR SHALL hold their last values outside REQ states.
REQ-036 I_ABORT in RD_REQ, PROC or WR_REQ -> FIN next cycle without O_START.
REQ-037 I_ABORT in RD_WAIT/WR_WAIT SHALL be latched and take effect at burst completion (-> FIN), never cutting an AHB burst.
REQ-038 I_ABORT and normal completion on the same cycle: abort wins unless the completed burst was the last write, in which case O_ABORTED stays 0.

Reset
REQ-039 On I_HRESET_N=0 at a clock edge: state IDLE; O_START, O_WRITE, O_BUSY, O_CORE_START, O_FRAME_BUSY, O_DONE, O_ABORTED = 0; O_ADDR = 0; O_BLOCK_IDX = 0; latched abort and ready-drop flags cleared.
REQ-040 Reset mid-frame SHALL return to IDLE without O_DONE.

Structure
REQ-041 State encoding and HSIZE_WORD constant SHALL live in a shared rotate package.
REQ-042 Single module; address generation SHALL be one adder shared between read and write paths, no sub-modules.

Verification
REQ-043 NUM_BLOCKS=2, src=0x1000, dst=0x8000 -> O_START addrs 0x1000(R),0x8000(W),0x1040(R),0x8040(W), one O_DONE, O_ABORTED=0.
REQ-044 NUM_BLOCKS=0 -> O_DONE two cycles after I_GO, no O_START.
REQ-045 I_DMA_READY held 1 after O_START for 5 cycles then 0 then 1 -> state leaves RD_WAIT only after the 0->1.
REQ-046 I_ABORT pulsed during first RD_WAIT -> burst waited out, no O_CORE_START, O_DONE with O_ABORTED=1.
REQ-047 I_GO during PROC and I_CORE_DONE during IDLE -> both ignored, no state change.
REQ-048 Reset asserted in WR_WAIT -> next cycle all outputs at reset values, no O_DONE.

Source files
------------

// File: rtl/rot_dma_seq_pkg.sv
// Shared definitions for the rotation DMA sequencer: state encoding, default
// AHB transfer size and the burst byte-offset helper.
package rot_dma_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_PROC    = 3'd3,
        ST_WR_REQ  = 3'd4,
        ST_WR_WAIT = 3'd5,
        ST_FIN     = 3'd6
    } state_e;

    localparam logic [2:0] HSIZE_WORD_DFLT = 3'b010;

    // Byte offset of block idx inside a frame; wraps modulo 2^32.
    function automatic logic [31:0] burst_offset(input logic [15:0]   idx,
                                                 input int unsigned  burst_words);
        return 32'(idx) * (32'(burst_words) << 2);
    endfunction

endpackage

// File: rtl/rot_dma_seq.sv
// Frame sequencer: per block, read burst -> rotation core -> write burst; one adder
// forms both burst addresses. Waits on DMA ready drop/rise; aborts never cut a burst.
module rot_dma_seq
    import rot_dma_seq_pkg::*;
#(
    parameter int unsigned BURST_WORDS = 16,
    parameter logic [2:0]  HSIZE_WORD  = HSIZE_WORD_DFLT
) (
    input  logic        I_HCLK,
    input  logic        I_HRESET_N,
    input  logic        I_GO,
    input  logic        I_ABORT,
    input  logic [31:0] I_SRC_ADDR,
    input  logic [31:0] I_DST_ADDR,
    input  logic [15:0] I_NUM_BLOCKS,
    input  logic        I_PAUSE,
    input  logic        I_DMA_READY,
    input  logic        I_CORE_DONE,
    output logic        O_START,
    output logic [31:0] O_ADDR,
    output logic [2:0]  O_SIZE,
    output logic [4:0]  O_COUNT,
    output logic        O_WRITE,
    output logic        O_BUSY,
    output logic        O_CORE_START,
    output logic        O_FRAME_BUSY,
    output logic        O_DONE,
    output logic        O_ABORTED,
    output logic [15:0] O_BLOCK_IDX
);

    state_e      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] nblk_q, nblk_d;
    logic [15:0] idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic        abort_q, abort_d;
    logic        drop_q, drop_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;

    logic        in_wait;
    logic        burst_done;
    logic        abort_now;
    logic        last_blk;
    logic        start;
    logic        core_start;
    logic [31:0] add_base;
    logic [31:0] add_sum;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        nblk_d     = nblk_q;
        idx_d      = idx_q;
        abort_d    = abort_q;
        done_d     = 1'b0;
        aborted_d  = aborted_q;
        addr_d     = addr_q;
        write_d    = write_q;
        start      = 1'b0;
        core_start = 1'b0;

        in_wait    = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
        // A ready level only counts once it has been seen low inside this wait.
        burst_done = in_wait && drop_q && I_DMA_READY;
        drop_d     = in_wait && !burst_done && (drop_q || !I_DMA_READY);
        abort_now  = abort_q || I_ABORT;
        last_blk   = (idx_q == nblk_q - 16'd1);

        case (state_q)
            ST_IDLE: begin
                if (I_GO) begin
                    src_d     = I_SRC_ADDR;
                    dst_d     = I_DST_ADDR;
                    nblk_d    = I_NUM_BLOCKS;
                    idx_d     = 16'd0;
                    abort_d   = 1'b0;
                    aborted_d = 1'b0;
                    state_d   = (I_NUM_BLOCKS == 16'd0) ? ST_FIN : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (I_ABORT) begin
                    abort_d = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    start   = 1'b1;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                abort_d = abort_now;
                if (burst_done) begin
                    if (abort_now) begin
                        state_d = ST_FIN;
                    end else begin
                        core_start = 1'b1;
                        state_d    = ST_PROC;
                    end
                end
            end
            ST_PROC: begin
                if (I_ABORT) begin
                    abort_d = 1'b1;
                    state_d = ST_FIN;
                end else if (I_CORE_DONE) begin
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (I_ABORT) begin
                    abort_d = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    start   = 1'b1;
                    state_d = ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                abort_d = abort_now;
                if (burst_done) begin
                    if (last_blk) begin
                        // The frame's data is fully written back: report a clean finish.
                        abort_d = 1'b0;
                        state_d = ST_FIN;
                    end else if (abort_now) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_FIN: begin
                done_d    = 1'b1;
                aborted_d = abort_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        add_base = (state_d == ST_WR_REQ) ? dst_d : src_d;
        add_sum  = add_base + burst_offset(idx_d, BURST_WORDS);
        if ((state_d == ST_RD_REQ || state_d == ST_WR_REQ) && state_d != state_q) begin
            addr_d  = add_sum;
            write_d = (state_d == ST_WR_REQ);
        end
    end

    always_ff @(posedge I_HCLK) begin
        if (!I_HRESET_N) begin
            state_q   <= ST_IDLE;
            src_q     <= 32'd0;
            dst_q     <= 32'd0;
            nblk_q    <= 16'd0;
            idx_q     <= 16'd0;
            addr_q    <= 32'd0;
            write_q   <= 1'b0;
            abort_q   <= 1'b0;
            drop_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            nblk_q    <= nblk_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            abort_q   <= abort_d;
            drop_q    <= drop_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign O_START      = start;
    assign O_ADDR       = addr_q;
    assign O_SIZE       = HSIZE_WORD;
    assign O_COUNT      = 5'(BURST_WORDS);
    assign O_WRITE      = write_q;
    assign O_BUSY       = in_wait && I_PAUSE;
    assign O_CORE_START = core_start;
    assign O_FRAME_BUSY = (state_q != ST_IDLE);
    assign O_DONE       = done_q;
    assign O_ABORTED    = aborted_q;
    assign O_BLOCK_IDX  = idx_q;

endmodule

// File: tb/tb_rot_dma_seq.sv
// Randomized scoreboard bench for rot_dma_seq with DMA/core responders and
// directed frames for timing, abort and reset corner cases.
module tb_rot_dma_seq;

    localparam int          BW     = 16;
    localparam logic [31:0] STRIDE = 32'(BW * 4);

    logic        I_HCLK;
    logic        I_HRESET_N;
    logic        I_GO;
    logic        I_ABORT;
    logic [31:0] I_SRC_ADDR;
    logic [31:0] I_DST_ADDR;
    logic [15:0] I_NUM_BLOCKS;
    logic        I_PAUSE;
    logic        I_DMA_READY;
    logic        I_CORE_DONE;
    logic        O_START;
    logic [31:0] O_ADDR;
    logic [2:0]  O_SIZE;
    logic [4:0]  O_COUNT;
    logic        O_WRITE;
    logic        O_BUSY;
    logic        O_CORE_START;
    logic        O_FRAME_BUSY;
    logic        O_DONE;
    logic        O_ABORTED;
    logic [15:0] O_BLOCK_IDX;

    logic abort_m, abort_r, core_m, core_r;
    bit   pause_en;
    int   dma_hi = -1;
    int   dma_lo = -1;
    int   burst_cnt = 0;
    int   abort_burst = -1;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
    } start_t;

    start_t exp_start_q[$];
    logic   exp_done_q[$];

    assign I_ABORT     = abort_m | abort_r;
    assign I_CORE_DONE = core_m | core_r;

    rot_dma_seq #(.BURST_WORDS(BW), .HSIZE_WORD(3'b010)) dut (
        .I_HCLK(I_HCLK), .I_HRESET_N(I_HRESET_N), .I_GO(I_GO), .I_ABORT(I_ABORT),
        .I_SRC_ADDR(I_SRC_ADDR), .I_DST_ADDR(I_DST_ADDR), .I_NUM_BLOCKS(I_NUM_BLOCKS),
        .I_PAUSE(I_PAUSE), .I_DMA_READY(I_DMA_READY), .I_CORE_DONE(I_CORE_DONE),
        .O_START(O_START), .O_ADDR(O_ADDR), .O_SIZE(O_SIZE), .O_COUNT(O_COUNT),
        .O_WRITE(O_WRITE), .O_BUSY(O_BUSY), .O_CORE_START(O_CORE_START),
        .O_FRAME_BUSY(O_FRAME_BUSY), .O_DONE(O_DONE), .O_ABORTED(O_ABORTED),
        .O_BLOCK_IDX(O_BLOCK_IDX)
    );

    initial I_HCLK = 1'b0;
    always #5 I_HCLK = ~I_HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void push_start(input logic [31:0] a, input logic w);
        start_t e;
        e.addr = a;
        e.wr   = w;
        exp_start_q.push_back(e);
    endfunction

    // Reference model: a clean frame is n (read, write) pairs at base + b*stride, then one done.
    function automatic void push_normal(input logic [31:0] src, input logic [31:0] dst, input int n);
        for (int b = 0; b < n; b++) begin
            push_start(src + 32'(b) * STRIDE, 1'b0);
            push_start(dst + 32'(b) * STRIDE, 1'b1);
        end
        exp_done_q.push_back(1'b0);
    endfunction

    // DMA engine: after each start, ready stays high hi cycles, low lo cycles, then high.
    initial begin
        I_DMA_READY = 1'b1;
        abort_r     = 1'b0;
        forever begin
            int hi, lo, b;
            @(negedge I_HCLK);
            if (O_START && I_HRESET_N) begin
                b = burst_cnt;
                burst_cnt++;
                hi = (dma_hi >= 0) ? dma_hi : int'($urandom_range(0, 3));
                lo = (dma_lo > 0) ? dma_lo : int'($urandom_range(1, 3));
                @(posedge I_HCLK); #1;
                for (int i = 0; i < hi; i++) begin
                    I_DMA_READY = 1'b1;
                    @(posedge I_HCLK); #1;
                end
                I_DMA_READY = 1'b0;
                for (int i = 0; i < lo; i++) begin
                    @(posedge I_HCLK); #1;
                end
                I_DMA_READY = 1'b1;
                abort_r     = (b == abort_burst);
                @(posedge I_HCLK); #1;
                abort_r = 1'b0;
            end
        end
    end

    initial begin
        core_r = 1'b0;
        forever begin
            int d;
            @(negedge I_HCLK);
            if (O_CORE_START && I_HRESET_N) begin
                d = int'($urandom_range(2, 5));
                for (int i = 0; i < d; i++) @(posedge I_HCLK);
                #1 core_r = 1'b1;
                @(posedge I_HCLK);
                #1 core_r = 1'b0;
            end
        end
    end

    initial begin
        I_PAUSE = 1'b0;
        forever begin
            @(posedge I_HCLK); #1;
            I_PAUSE = pause_en && ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor: every start and done the DUT presents is matched against the scoreboard.
    initial begin
        forever begin
            start_t e;
            logic   ab;
            @(negedge I_HCLK);
            if (I_HRESET_N) begin
                if (O_START) begin
                    if (exp_start_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL start_unexpected: got addr 0x%08h write %0b, expected no start",
                                 O_ADDR, O_WRITE);
                    end else begin
                        e = exp_start_q.pop_front();
                        chk("start_addr", O_ADDR, e.addr);
                        chk("start_write", 32'(O_WRITE), 32'(e.wr));
                    end
                end
                if (O_DONE) begin
                    if (exp_done_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected: got done aborted=%0b, expected no done", O_ABORTED);
                    end else begin
                        ab = exp_done_q.pop_front();
                        chk("done_aborted", 32'(O_ABORTED), 32'(ab));
                    end
                end
                if (O_BUSY) chk("busy_needs_pause", 32'(I_PAUSE), 32'd1);
            end
        end
    end

    task automatic cyc();
        @(posedge I_HCLK); #1;
    endtask

    task automatic start_frame(input logic [31:0] src, input logic [31:0] dst,
                               input logic [15:0] n, input bit abort_req);
        cyc();
        I_GO = 1'b1; I_SRC_ADDR = src; I_DST_ADDR = dst; I_NUM_BLOCKS = n;
        cyc();
        I_GO = 1'b0; I_SRC_ADDR = $urandom; I_DST_ADDR = $urandom;
        I_NUM_BLOCKS = 16'($urandom); abort_m = abort_req;
    endtask

    // which: 0 = any start, 1 = core start, 2 = write start
    task automatic wait_sig(input int which, input int max, input string name, output int cycles);
        bit found = 0;
        cycles = 0;
        for (int i = 1; i <= max && !found; i++) begin
            @(negedge I_HCLK);
            cycles = i;
            case (which)
                0:       found = O_START;
                1:       found = O_CORE_START;
                default: found = O_START && O_WRITE;
            endcase
        end
        chk(name, 32'(found), 32'd1);
    endtask

    task automatic wait_done(input int max, input bit spurious, output int core_cnt);
        bit seen = 0;
        bit go_next = 0;
        core_cnt = 0;
        for (int i = 0; i < max && !seen; i++) begin
            cyc();
            I_GO = go_next;
            if (go_next) begin
                I_SRC_ADDR = $urandom; I_DST_ADDR = $urandom;
                I_NUM_BLOCKS = 16'($urandom_range(1, 9));
            end
            go_next = 0;
            @(negedge I_HCLK);
            if (O_DONE) seen = 1;
            if (O_CORE_START) core_cnt++;
            // A start cycle is always followed by a wait cycle, where GO must be ignored.
            if (spurious && O_START && $urandom_range(0, 1) == 1) go_next = 1;
        end
        I_GO = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int cc, lat;
        logic [31:0] src, dst;
        int n;

        I_HRESET_N = 1'b0; I_GO = 1'b0; I_SRC_ADDR = '0; I_DST_ADDR = '0;
        I_NUM_BLOCKS = '0; abort_m = 1'b0; core_m = 1'b0; pause_en = 1'b0;
        repeat (3) cyc();
        @(negedge I_HCLK);
        chk("rst_start", 32'(O_START), 32'd0);
        chk("rst_write", 32'(O_WRITE), 32'd0);
        chk("rst_busy", 32'(O_BUSY), 32'd0);
        chk("rst_core_start", 32'(O_CORE_START), 32'd0);
        chk("rst_frame_busy", 32'(O_FRAME_BUSY), 32'd0);
        chk("rst_done", 32'(O_DONE), 32'd0);
        chk("rst_aborted", 32'(O_ABORTED), 32'd0);
        chk("rst_addr", O_ADDR, 32'd0);
        chk("rst_block_idx", 32'(O_BLOCK_IDX), 32'd0);
        chk("size_const", 32'(O_SIZE), 32'd2);
        chk("count_const", 32'(O_COUNT), 32'd16);
        cyc();
        I_HRESET_N = 1'b1;
        repeat (2) cyc();

        // Two-block frame with known addresses.
        push_normal(32'h0000_1000, 32'h0000_8000, 2);
        start_frame(32'h0000_1000, 32'h0000_8000, 16'd2, 1'b0);
        wait_done(500, 1'b0, cc);
        chk("two_blk_core_starts", 32'(cc), 32'd2);
        repeat (3) cyc();

        // Zero blocks: done two cycles after GO, no bursts.
        exp_done_q.push_back(1'b0);
        start_frame(32'h0000_2000, 32'h0000_3000, 16'd0, 1'b0);
        @(negedge I_HCLK);
        chk("zero_blk_fin_busy", 32'(O_FRAME_BUSY), 32'd1);
        chk("zero_blk_done_early", 32'(O_DONE), 32'd0);
        @(negedge I_HCLK);
        chk("zero_blk_done", 32'(O_DONE), 32'd1);
        repeat (3) cyc();

        // Ready held high for 5 cycles before dropping: only the later rise completes.
        dma_hi = 5; dma_lo = 2;
        push_normal(32'h0001_0000, 32'h0002_0000, 1);
        start_frame(32'h0001_0000, 32'h0002_0000, 16'd1, 1'b0);
        wait_sig(0, 20, "rd_start_seen", lat);
        wait_sig(1, 40, "core_start_seen", lat);
        chk("rd_wait_latency", 32'(lat), 32'(1 + 5 + 2));
        dma_hi = -1; dma_lo = -1;
        wait_done(500, 1'b0, cc);
        repeat (3) cyc();

        // Abort pulsed during the first read wait: burst completes, frame ends aborted.
        push_start(32'h0003_0000, 1'b0);
        exp_done_q.push_back(1'b1);
        start_frame(32'h0003_0000, 32'h0004_0000, 16'd3, 1'b0);
        wait_sig(0, 20, "abort_rd_start_seen", lat);
        cyc(); abort_m = 1'b1;
        cyc(); abort_m = 1'b0;
        wait_done(500, 1'b0, cc);
        chk("abort_rd_no_core_start", 32'(cc), 32'd0);
        repeat (3) cyc();

        // Abort in the first read request cycle: no burst at all.
        exp_done_q.push_back(1'b1);
        start_frame(32'h0005_0000, 32'h0006_0000, 16'd2, 1'b1);
        cyc(); abort_m = 1'b0;
        wait_done(50, 1'b0, cc);
        repeat (3) cyc();

        // Abort in PROC: no write burst follows.
        push_start(32'h0007_0000, 1'b0);
        exp_done_q.push_back(1'b1);
        start_frame(32'h0007_0000, 32'h0008_0000, 16'd2, 1'b0);
        wait_sig(1, 50, "proc_abort_core_seen", lat);
        cyc(); abort_m = 1'b1;
        cyc(); abort_m = 1'b0;
        wait_done(50, 1'b0, cc);
        repeat (8) cyc();

        // Abort coinciding with a non-final write completion ends the frame aborted.
        abort_burst = burst_cnt + 1;
        push_start(32'h0009_0000, 1'b0);
        push_start(32'h000A_0000, 1'b1);
        exp_done_q.push_back(1'b1);
        start_frame(32'h0009_0000, 32'h000A_0000, 16'd2, 1'b0);
        wait_done(500, 1'b0, cc);
        repeat (4) cyc();

        // Abort coinciding with the final write completion: clean finish.
        abort_burst = burst_cnt + 3;
        push_normal(32'h000B_0000, 32'h000C_0000, 2);
        start_frame(32'h000B_0000, 32'h000C_0000, 16'd2, 1'b0);
        wait_done(500, 1'b0, cc);
        abort_burst = -1;
        repeat (4) cyc();

        // GO during PROC and CORE_DONE during IDLE are both ignored.
        push_normal(32'h000D_0000, 32'h000E_0000, 1);
        start_frame(32'h000D_0000, 32'h000E_0000, 16'd1, 1'b0);
        wait_sig(1, 50, "ign_core_seen", lat);
        cyc();
        I_GO = 1'b1; I_SRC_ADDR = 32'hDEAD_0000; I_DST_ADDR = 32'hBEEF_0000; I_NUM_BLOCKS = 16'd5;
        cyc(); I_GO = 1'b0;
        wait_done(500, 1'b0, cc);
        repeat (2) cyc();
        core_m = 1'b1;
        cyc(); core_m = 1'b0;
        @(negedge I_HCLK);
        chk("idle_core_done_ignored", 32'(O_FRAME_BUSY), 32'd0);
        repeat (5) cyc();

        // Reset while in the second write wait: everything returns to reset values, no done.
        push_start(32'h0010_0000, 1'b0);
        push_start(32'h0020_0000, 1'b1);
        push_start(32'h0010_0040, 1'b0);
        push_start(32'h0020_0040, 1'b1);
        start_frame(32'h0010_0000, 32'h0020_0000, 16'd2, 1'b0);
        wait_sig(2, 200, "rst_w0_seen", lat);
        wait_sig(2, 200, "rst_w1_seen", lat);
        cyc(); I_HRESET_N = 1'b0;
        cyc();
        @(negedge I_HCLK);
        chk("midrst_write", 32'(O_WRITE), 32'd0);
        chk("midrst_addr", O_ADDR, 32'd0);
        chk("midrst_frame_busy", 32'(O_FRAME_BUSY), 32'd0);
        chk("midrst_done", 32'(O_DONE), 32'd0);
        chk("midrst_block_idx", 32'(O_BLOCK_IDX), 32'd0);
        chk("midrst_start", 32'(O_START), 32'd0);
        cyc(); I_HRESET_N = 1'b1;
        repeat (15) cyc();
        chk("midrst_queue_empty", 32'(exp_start_q.size() + exp_done_q.size()), 32'd0);

        // Randomized frames with pauses and GO pulses during bursts.
        pause_en = 1'b1;
        for (int f = 0; f < 25; f++) begin
            n   = int'($urandom_range(0, 5));
            src = $urandom;
            dst = $urandom;
            if ($urandom_range(0, 3) == 0) src = 32'hFFFF_FF00;
            push_normal(src, dst, n);
            start_frame(src, dst, 16'(n), 1'b0);
            wait_done(2000, 1'b1, cc);
            chk("rand_core_starts", 32'(cc), 32'(n));
            repeat (int'($urandom_range(1, 3))) cyc();
        end
        pause_en = 1'b0;
        repeat (5) cyc();

        chk("final_queue_empty", 32'(exp_start_q.size() + exp_done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
